// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: HD44780-style character-LCD bus responder with a 128x8 DDRAM,
// address counter, busy flag, status/data reads and a registered DDRAM mirror port.
module lcd_bus_responder #(
   parameter int CMD_CYCLES = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       LCD_E,
   input  logic       LCD_RS,
   input  logic       LCD_RW,
   input  logic [7:0] LCD_DATA_IN,
   output logic [7:0] LCD_DATA_OUT,
   output logic       LCD_DATA_OE,
   output logic       BUSY,
   output logic       DISP_ON,
   output logic       TWO_LINE,
   output logic       ENTRY_INC,
   output logic       CMD_ERR,
   input  logic [6:0] RD_ADDR,
   output logic [7:0] RD_CHAR
);
   localparam logic [1:0] S_IDLE = 2'd0, S_EXEC = 2'd1, S_CLEAR = 2'd2;
   logic [1:0] r_state;
   logic [7:0] r_cnt, r_dout, r_rd_char;
   logic [6:0] r_clr, r_ac;
   logic       r_e_q, r_disp, r_two, r_inc, r_err, r_oe;
   logic [7:0] r_mem [128];
   logic       w_edge, w_busy, w_wr, w_cmd, w_dwr, w_drd, w_exec, w_clear, w_we;
   logic [6:0] w_adv, w_waddr;
   logic [7:0] w_wdata;

   // Out-of-range addresses (only reachable via set-address) snap back to 0x00.
   function automatic logic [6:0] f_adv(input logic [6:0] ac, input logic up, input logic two);
      logic [6:0] last;
      logic       valid;
      last  = two ? 7'h67 : 7'h4F;
      valid = two ? (ac <= 7'h27 || (ac >= 7'h40 && ac <= 7'h67)) : ac <= 7'h4F;
      if (!valid) return 7'h00;
      if (up) return ac == last ? 7'h00 : (two && ac == 7'h27) ? 7'h40 : ac + 7'd1;
      return ac == 7'h00 ? last : (two && ac == 7'h40) ? 7'h27 : ac - 7'd1;
   endfunction

   always_comb begin
      w_edge  = LCD_E & ~r_e_q;
      w_busy  = r_state != S_IDLE;
      w_wr    = w_edge & ~LCD_RW & ~w_busy;
      w_cmd   = w_wr & ~LCD_RS;
      w_dwr   = w_wr & LCD_RS;
      w_drd   = w_edge & LCD_RW & LCD_RS & ~w_busy;
      w_exec  = w_dwr | (w_cmd & |LCD_DATA_IN[7:1]);
      w_clear = w_cmd & (LCD_DATA_IN == 8'h01);
      // Data accesses follow ENTRY_INC; the cursor-shift command carries its own direction bit.
      w_adv   = f_adv(r_ac, LCD_RS ? r_inc : LCD_DATA_IN[2], r_two);
      w_we    = ~RESET & (r_state == S_CLEAR | w_dwr);
      w_waddr = r_state == S_CLEAR ? r_clr : r_ac;
      w_wdata = r_state == S_CLEAR ? 8'h20 : LCD_DATA_IN;
   end

   always_ff @(posedge CLK) begin
      r_e_q <= LCD_E;
      if (RESET) begin
         r_state <= S_CLEAR;
         r_clr   <= 7'h00;
         r_cnt   <= 8'h00;
         r_ac    <= 7'h00;
         r_disp  <= 1'b0;
         r_two   <= 1'b0;
         r_inc   <= 1'b1;
         r_err   <= 1'b0;
         r_dout  <= 8'h00;
         r_oe    <= 1'b0;
      end else begin
         r_err <= w_edge & w_busy & (~LCD_RW | LCD_RS);
         r_oe  <= (w_edge & LCD_RW) | (r_oe & LCD_E);
         if (w_edge & LCD_RW) r_dout <= ~LCD_RS ? {w_busy, r_ac} : w_busy ? 8'h00 : r_mem[r_ac];
         if (r_state == S_EXEC) begin
            r_cnt <= r_cnt - 8'd1;
            if (r_cnt == 8'd0) r_state <= S_IDLE;
         end
         if (r_state == S_CLEAR) begin
            r_clr <= r_clr + 7'd1;
            if (r_clr == 7'h7F) r_state <= S_IDLE;
         end
         if (w_drd | w_dwr) r_ac <= w_adv;
         if (w_cmd) begin
            casez (LCD_DATA_IN)
               8'b1???????: r_ac <= LCD_DATA_IN[6:0];
               8'b001?????: r_two <= LCD_DATA_IN[3];
               8'b0001????: if (!LCD_DATA_IN[3]) r_ac <= w_adv;
               8'b00001???: r_disp <= LCD_DATA_IN[2];
               8'b000001??: r_inc <= LCD_DATA_IN[1];
               8'b0000001?: r_ac <= 7'h00;
               8'b00000001: begin
                  r_ac  <= 7'h00;
                  r_inc <= 1'b1;
               end
               default: r_ac <= r_ac;
            endcase
         end
         if (w_exec) begin
            r_state <= S_EXEC;
            r_cnt   <= 8'(CMD_CYCLES - 1);
         end
         if (w_clear) begin
            r_state <= S_CLEAR;
            r_clr   <= 7'h00;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
      r_rd_char <= r_mem[RD_ADDR];
   end

   assign LCD_DATA_OUT = r_dout;
   assign LCD_DATA_OE  = r_oe;
   assign BUSY         = w_busy;
   assign DISP_ON      = r_disp;
   assign TWO_LINE     = r_two;
   assign ENTRY_INC    = r_inc;
   assign CMD_ERR      = r_err;
   assign RD_CHAR      = r_rd_char;
endmodule

// File: tb/tb_lcd_bus_responder.sv
// tb_lcd_bus_responder: drives the LCD bus and compares the responder against a
// transaction-level model of DDRAM, address counter, mode bits and busy durations.
module tb_lcd_bus_responder;
   localparam int CMD = 4;
   logic       clk = 1'b0, rst = 1'b1, e = 1'b0, rs = 1'b0, rw = 1'b0;
   logic [7:0] din = 8'h00;
   logic [6:0] rd_addr = 7'h00;
   logic [7:0] dout, rd_char;
   logic       oe, busy, disp, two, inc, err;
   int         n_total = 0, n_pass = 0;
   logic [7:0] m_mem [128];
   logic [6:0] m_ac;
   bit         m_two, m_inc, m_disp;

   lcd_bus_responder #(.CMD_CYCLES(CMD)) dut (
      .CLK(clk), .RESET(rst), .LCD_E(e), .LCD_RS(rs), .LCD_RW(rw), .LCD_DATA_IN(din),
      .LCD_DATA_OUT(dout), .LCD_DATA_OE(oe), .BUSY(busy), .DISP_ON(disp), .TWO_LINE(two),
      .ENTRY_INC(inc), .CMD_ERR(err), .RD_ADDR(rd_addr), .RD_CHAR(rd_char)
   );

   always #5 clk = ~clk;

   // Address counter as a position on an 80-character ring (one or two 40-char lines).
   function automatic logic [6:0] m_adv(input logic [6:0] a, input bit up);
      int idx;
      if (m_two) begin
         if (a <= 7'h27) idx = int'(a);
         else if (a >= 7'h40 && a <= 7'h67) idx = int'(a) - 64 + 40;
         else return 7'h00;
      end else begin
         if (a > 7'h4F) return 7'h00;
         idx = int'(a);
      end
      idx = (idx + (up ? 1 : 79)) % 80;
      return (m_two && idx >= 40) ? 7'(idx - 40 + 64) : 7'(idx);
   endfunction

   task automatic m_reset();
      foreach (m_mem[i]) m_mem[i] = 8'h20;
      m_ac = 7'h00; m_two = 1'b0; m_inc = 1'b1; m_disp = 1'b0;
   endtask

   task automatic m_cmd(input logic [7:0] d, output int bl);
      bl = (d == 8'h00) ? 0 : (d == 8'h01) ? 128 : CMD;
      if (d[7]) m_ac = d[6:0];
      else if (d[6]) begin end
      else if (d[5]) m_two = d[3];
      else if (d[4]) begin if (!d[3]) m_ac = m_adv(m_ac, d[2]); end
      else if (d[3]) m_disp = d[2];
      else if (d[2]) m_inc = d[1];
      else if (d[1]) m_ac = 7'h00;
      else if (d[0]) m_reset_keep_modes();
   endtask

   task automatic m_reset_keep_modes();
      foreach (m_mem[i]) m_mem[i] = 8'h20;
      m_ac = 7'h00; m_inc = 1'b1;
   endtask

   task automatic m_data_write(input logic [7:0] d);
      m_mem[m_ac] = d;
      m_ac = m_adv(m_ac, m_inc);
   endtask

   task automatic strobe(input bit s, input bit w, input logic [7:0] d);
      @(negedge clk); rs = s; rw = w; din = d; e = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic e_low();
      @(negedge clk); e = 1'b0;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 400) begin
         n++;
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_idle();
      int n;
      count_busy(n);
      if (busy !== 1'b0) begin
         n_total++;
         $display("FAIL wait_idle: busy still %b after %0d cycles, want 0", busy, n);
      end
   endtask

   task automatic wr(input bit s, input logic [7:0] d);
      int n, exp_n;
      wait_idle();
      strobe(s, 1'b0, d);
      if (s) begin m_data_write(d); exp_n = CMD; end
      else m_cmd(d, exp_n);
      count_busy(n);
      e_low();
      n_total++;
      if (n !== exp_n) $display("FAIL busy_len rs=%0b d=%02h: got %0d want %0d", s, d, n, exp_n);
      else n_pass++;
   endtask

   task automatic rd(input bit s, input logic [7:0] exp);
      wait_idle();
      strobe(s, 1'b1, 8'h00);
      if (s) m_ac = m_adv(m_ac, m_inc);
      n_total++;
      if (dout !== exp) $display("FAIL rd_data rs=%0b: got %02h want %02h", s, dout, exp); else n_pass++;
      n_total++;
      if (oe !== 1'b1) $display("FAIL rd_oe: got %b want 1", oe); else n_pass++;
      n_total++;
      if (busy !== 1'b0) $display("FAIL rd_no_busy: got %b want 0", busy); else n_pass++;
      e_low();
      @(posedge clk); #1;
      n_total++;
      if (oe !== 1'b0) $display("FAIL rd_oe_drop: got %b want 0", oe); else n_pass++;
   endtask

   task automatic mirror(input logic [6:0] a, input logic [7:0] exp);
      @(negedge clk); rd_addr = a;
      @(posedge clk); #1;
      n_total++;
      if (rd_char !== exp) $display("FAIL mirror[%02h]: got %02h want %02h", a, rd_char, exp);
      else n_pass++;
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_total += 7;
      if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy); else n_pass++;
      if (oe !== 1'b0) $display("FAIL reset_oe: got %b want 0", oe); else n_pass++;
      if (dout !== 8'h00) $display("FAIL reset_dout: got %02h want 00", dout); else n_pass++;
      if (disp !== 1'b0) $display("FAIL reset_disp: got %b want 0", disp); else n_pass++;
      if (two !== 1'b0) $display("FAIL reset_two: got %b want 0", two); else n_pass++;
      if (inc !== 1'b1) $display("FAIL reset_inc: got %b want 1", inc); else n_pass++;
      if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
      m_reset();
      @(negedge clk); rst = 1'b0;
      count_busy(n);
      n_total++;
      if (n !== 128) $display("FAIL reset_clear_len: got %0d want 128", n); else n_pass++;
      mirror(7'h05, 8'h20);
   endtask

   task automatic test_init();
      wr(0, 8'h3C); wr(0, 8'h0C); wr(0, 8'h06); wr(0, 8'h84);
      wr(1, 8'h31); wr(1, 8'h32);
      n_total += 3;
      if (two !== 1'b1) $display("FAIL init_two: got %b want 1", two); else n_pass++;
      if (disp !== 1'b1) $display("FAIL init_disp: got %b want 1", disp); else n_pass++;
      if (inc !== 1'b1) $display("FAIL init_inc: got %b want 1", inc); else n_pass++;
      mirror(7'h04, 8'h31);
      mirror(7'h05, 8'h32);
      rd(0, 8'h06);
   endtask

   task automatic test_ac_wrap();
      wr(0, 8'hA7); wr(1, 8'h41); rd(0, 8'h40);
      wr(0, 8'hE7); wr(1, 8'h42); rd(0, 8'h00);
      wr(0, 8'h04); wr(0, 8'hC0); wr(1, 8'h43); rd(0, 8'h27);
      wr(0, 8'h06);
      wr(0, 8'h30);
      n_total++;
      if (two !== 1'b0) $display("FAIL one_line_two: got %b want 0", two); else n_pass++;
      wr(0, 8'hCF); wr(1, 8'h44); rd(0, 8'h00);
      wr(0, 8'hF0); wr(1, 8'h45); rd(0, 8'h00);
      mirror(7'h70, 8'h45);
      wr(0, 8'h85); wr(0, 8'h14); rd(0, 8'h06);
      wr(0, 8'h10); wr(0, 8'h10); rd(0, 8'h04);
      wr(0, 8'h18); rd(0, 8'h04);
      wr(0, 8'h3C);
   endtask

   task automatic test_busy_reject();
      logic [6:0] a0;
      wait_idle();
      a0 = m_ac;
      strobe(1, 0, 8'h55);
      m_data_write(8'h55);
      n_total++;
      if (err !== 1'b0) $display("FAIL accept_err: got %b want 0", err); else n_pass++;
      e_low();
      @(negedge clk); rs = 1'b1; rw = 1'b0; din = 8'hAA; e = 1'b1;
      @(posedge clk); #1;
      n_total++;
      if (err !== 1'b1) $display("FAIL reject_err: got %b want 1", err); else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (err !== 1'b0) $display("FAIL reject_err_pulse: got %b want 0", err); else n_pass++;
      e_low();
      wait_idle();
      mirror(a0, 8'h55);
      mirror(m_ac, m_mem[m_ac]);
      rd(0, {1'b0, m_ac});
      // edge landing on the last busy cycle
      wait_idle();
      strobe(1, 0, 8'h66);
      m_data_write(8'h66);
      e_low();
      repeat (2) @(negedge clk);
      @(negedge clk); rs = 1'b1; rw = 1'b0; din = 8'h77; e = 1'b1;
      @(posedge clk); #1;
      n_total += 2;
      if (err !== 1'b1) $display("FAIL last_busy_err: got %b want 1", err); else n_pass++;
      if (busy !== 1'b0) $display("FAIL last_busy_no_exec: got %b want 0", busy); else n_pass++;
      e_low();
      mirror(m_ac, m_mem[m_ac]);
      // data read while busy
      wait_idle();
      strobe(1, 0, 8'h68);
      m_data_write(8'h68);
      e_low();
      @(negedge clk); rs = 1'b1; rw = 1'b1; e = 1'b1;
      @(posedge clk); #1;
      n_total += 3;
      if (err !== 1'b1) $display("FAIL busy_rd_err: got %b want 1", err); else n_pass++;
      if (dout !== 8'h00) $display("FAIL busy_rd_data: got %02h want 00", dout); else n_pass++;
      if (oe !== 1'b1) $display("FAIL busy_rd_oe: got %b want 1", oe); else n_pass++;
      e_low();
      rd(0, {1'b0, m_ac});
   endtask

   task automatic test_clear_status();
      int bl;
      wait_idle();
      strobe(0, 0, 8'h01);
      m_cmd(8'h01, bl);
      e_low();
      repeat (5) @(posedge clk);
      strobe(0, 1, 8'h00);
      n_total += 3;
      if (dout !== 8'h80) $display("FAIL clr_status: got %02h want 80", dout); else n_pass++;
      if (oe !== 1'b1) $display("FAIL clr_status_oe: got %b want 1", oe); else n_pass++;
      if (busy !== 1'b1) $display("FAIL clr_busy: got %b want 1", busy); else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (oe !== 1'b1) $display("FAIL clr_oe_hold: got %b want 1", oe); else n_pass++;
      e_low();
      @(posedge clk); #1;
      n_total++;
      if (oe !== 1'b0) $display("FAIL clr_oe_drop: got %b want 0", oe); else n_pass++;
      wr(0, 8'h84); wr(1, 8'h31); wr(0, 8'h84);
      rd(1, 8'h31);
      rd(0, 8'h05);
   endtask

   task automatic test_reset_mid_clear();
      int n;
      wr(0, 8'hF0); wr(1, 8'h99);
      mirror(7'h70, 8'h99);
      wait_idle();
      strobe(0, 0, 8'h01);
      e_low();
      repeat (59) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_total++;
      if (busy !== 1'b1) $display("FAIL midreset_busy: got %b want 1", busy); else n_pass++;
      m_reset();
      @(negedge clk); rst = 1'b0;
      count_busy(n);
      n_total++;
      if (n !== 128) $display("FAIL midreset_clear_len: got %0d want 128", n); else n_pass++;
      for (int a = 0; a < 128; a++) mirror(7'(a), 8'h20);
   endtask

   task automatic test_random();
      logic [6:0] a;
      for (int it = 0; it < 150; it++) begin
         case ($urandom_range(0, 4))
            0: wr(0, 8'($urandom_range(0, 255)));
            1: wr(0, 8'h80 | 8'($urandom_range(0, 127)));
            2: wr(1, 8'($urandom_range(0, 255)));
            3: rd(1, m_mem[m_ac]);
            default: rd(0, {1'b0, m_ac});
         endcase
         a = 7'($urandom_range(0, 127));
         mirror(a, m_mem[a]);
         n_total++;
         if ({disp, two, inc} !== {m_disp, m_two, m_inc})
            $display("FAIL rand_modes: got %b%b%b want %b%b%b", disp, two, inc, m_disp, m_two, m_inc);
         else n_pass++;
      end
      rd(0, {1'b0, m_ac});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_init();
      test_ac_wrap();
      test_busy_reject();
      test_clear_status();
      test_reset_mid_clear();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
